lvds_tx_arbiter: RTL and testbench
==================================

LVDS_TX_ARBITER -- requirements
Module: lvds_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TURN, default 2: the number of bus-turnaround cycles with the driver tri-stated after each word; legal range 1..15.
REQ-002 The block SHALL have parameter DW, default 8: the data word width in bits.
REQ-003 Port C SHALL be an input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 Port CLR SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port REQ0 SHALL be an input, 1 bit: requester 0 transfer request, level, held until ACK0.
REQ-006 Port DATA0 SHALL be an input, DW bits: requester 0 word, sampled at grant.
REQ-007 Port ACK0 SHALL be an output, 1 bit: one-cycle pulse marking that requester 0's word is complete.
REQ-008 Ports REQ1, DATA1 and ACK1 SHALL match REQ0, DATA0 and ACK0 for requester 1.
REQ-009 Port GNT SHALL be an output, 2 bits: one-hot current owner; 00 when the bus is idle.
REQ-010 Port I_OUT SHALL be an output, 1 bit: serial data to the differential tri-state buffer I input.
REQ-011 Port T_OUT SHALL be an output, 1 bit: tri-state control to the buffer T input; 1 = high-Z.
REQ-012 Port BUSY SHALL be an output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and GAP; all outputs SHALL be registered.
REQ-014 IDLE outputs SHALL be T_OUT=1, I_OUT=0, GNT=00, BUSY=0.
REQ-015 IDLE transition: when any REQ is sampled high at edge k, the FSM SHALL grant one requester, latch its DATA into the shift register, set GNT, and enter START at edge k.
REQ-016 Arbitration SHALL be two-way round-robin: with both requests high, the requester not served last wins; after reset, requester 0 has priority.
REQ-017 START SHALL last 1 cycle with T_OUT=0, I_OUT=1 (start bit).
REQ-018 DATA SHALL last DW cycles with T_OUT=0, driving the latched word LSB first; the bit counter SHALL be $clog2(DW) bits wide and SHALL exit at count DW-1.
REQ-019 STOP SHALL last 1 cycle with T_OUT=0, I_OUT=0; the granted ACK SHALL be 1 during exactly this cycle.
REQ-020 GAP SHALL last TURN cycles with T_OUT=1, I_OUT=0, GNT held; the FSM SHALL then return to IDLE with GNT=00.
REQ-021 The driver SHALL be enabled for exactly DW+2 consecutive cycles per word, and T_OUT SHALL never be 0 in IDLE or GAP.
REQ-022 Changes on DATAx after grant SHALL NOT affect the word in flight.
REQ-023 A REQ that deasserts mid-transfer SHALL NOT abort the transfer; ACK still pulses.
REQ-024 A REQ still high in the cycle after its ACK SHALL be treated as a new request, arbitrated at the first IDLE edge.
REQ-025 A REQ arriving during GAP SHALL wait; the minimum spacing between successive words SHALL be DW+3+TURN cycles.
REQ-026 ACK0 and ACK1 SHALL never be 1 in the same cycle.

Reset
REQ-027 Asserting CLR SHALL immediately, without a clock, force: FSM=IDLE, T_OUT=1, I_OUT=0, GNT=00, ACK0=ACK1=0, BUSY=0, counters=0, round-robin pointer so that requester 0 has priority.
REQ-028 A word in flight when CLR asserts SHALL be dropped with no ACK.
REQ-029 The first grant after CLR deasserts SHALL occur no earlier than the first rising edge of C with CLR low.

Structure
REQ-030 Shared package lvds_tx_pkg SHALL hold: the state enumeration, the default DW, and the 2-bit GNT encodings.
REQ-031 The round-robin arbiter SHALL be the single sub-module lvds_rr_arb2 (inputs: request pair, advance strobe; output: one-hot grant).
REQ-032 The FSM, shift register and counters SHALL reside in lvds_tx_arbiter.

Verification
REQ-033 Single word: REQ0=1, DATA0=0xA5, TURN=2 -> T_OUT low for 10 cycles, I_OUT = 1,1,0,1,0,0,1,0,1,0; ACK0 pulses in the 10th cycle; T_OUT high for 2 cycles; then IDLE.
REQ-034 Contention: REQ0=REQ1=1 held from reset, DATA0=0x01, DATA1=0x80 -> GNT sequence 01,10,01,10; ACKs alternate; spacing 13 cycles.
REQ-035 Data stability: change DATA1 from 0x3C to 0xFF one cycle after grant -> 0x3C is serialized.
REQ-036 Mid-word reset: assert CLR during DATA bit 4 -> T_OUT=1 asynchronously; no ACK; the next REQ1 is served normally.
REQ-037 Turnaround: TURN=1 and TURN=15 with back-to-back REQ0 -> gap of exactly 1 and 15 high-Z cycles; T_OUT never low outside START/DATA/STOP.
REQ-038 Early drop: REQ1 deasserted in START -> full word sent, ACK1 pulses once, no second grant.

Source files
------------

// File: rtl/lvds_tx_pkg.sv
// ---------------------------------------------------------------------------
// lvds_tx_pkg
// Shared definitions for the LVDS transmit arbiter: the FSM state
// enumeration, the default data word width and the one-hot grant encodings.
// ---------------------------------------------------------------------------
package lvds_tx_pkg;

    localparam int DEFAULT_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } state_t;

    // One-hot owner encodings carried on GNT.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

endpackage

// File: rtl/lvds_rr_arb2.sv
// ---------------------------------------------------------------------------
// lvds_rr_arb2
// Two-way round-robin arbiter. The grant is a combinational function of the
// request pair and a one-bit priority pointer; the pointer moves only when
// the owner pulses adv, so a grant offered but not taken changes nothing.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (requester 0 gets priority)
//   req  : request pair, bit 0 = requester 0, bit 1 = requester 1
//   adv  : strobe, the current grant has been accepted
//   gnt  : one-hot grant, 00 when nobody requests
// ---------------------------------------------------------------------------
module lvds_rr_arb2
    import lvds_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    // 1 means requester 1 wins a tie (requester 0 was served last).
    logic prio1;

    always_comb begin
        gnt = GNT_NONE;
        if (req[0] && (!req[1] || !prio1)) begin
            gnt = GNT_0;
        end else if (req[1]) begin
            gnt = GNT_1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio1 <= 1'b0;
        end else if (adv) begin
            prio1 <= gnt[0];
        end
    end

endmodule

// File: rtl/lvds_tx_arbiter.sv
// ---------------------------------------------------------------------------
// lvds_tx_arbiter
// Shares one LVDS tri-state transmitter between two requesters. Each granted
// word is sent as a start bit (1), DW data bits LSB first and a stop bit (0)
// with the driver enabled, followed by TURN high-Z turnaround cycles.
// All outputs come straight from flops.
//
// Ports
//   C             : clock, rising edge
//   CLR           : asynchronous active-high reset
//   REQ0 / REQ1   : level requests, held until the matching ACK
//   DATA0 / DATA1 : words, captured at the grant edge
//   ACK0 / ACK1   : one-cycle pulse during the stop bit of that word
//   GNT           : one-hot owner, 00 when idle
//   I_OUT         : serial data to the buffer I input
//   T_OUT         : buffer tri-state control, 1 = high-Z
//   BUSY          : 1 whenever the FSM is not idle
// ---------------------------------------------------------------------------
module lvds_tx_arbiter
    import lvds_tx_pkg::*;
#(
    parameter int TURN = 2,
    parameter int DW   = DEFAULT_DW
) (
    input  logic          C,
    input  logic          CLR,
    input  logic          REQ0,
    input  logic [DW-1:0] DATA0,
    output logic          ACK0,
    input  logic          REQ1,
    input  logic [DW-1:0] DATA1,
    output logic          ACK1,
    output logic [1:0]    GNT,
    output logic          I_OUT,
    output logic          T_OUT,
    output logic          BUSY
);

    localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(DW - 1);
    localparam logic [3:0]    GAP_LAST = 4'(TURN - 1);

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [3:0]    gap_cnt;
    logic [DW-1:0] shreg;
    logic [1:0]    arb_gnt;
    logic          grant_take;

    // The arbiter is only consulted in IDLE, so requests that change while
    // a word is in flight cannot disturb it.
    assign grant_take = (state == ST_IDLE) && (arb_gnt != GNT_NONE);

    lvds_rr_arb2 u_arb (
        .clk (C),
        .rst (CLR),
        .req ({REQ1, REQ0}),
        .adv (grant_take),
        .gnt (arb_gnt)
    );

    // Shift register holds only data, so it carries no reset. It is loaded
    // at the grant edge and shifted as each bit is presented on I_OUT.
    always_ff @(posedge C) begin
        if (grant_take) begin
            shreg <= arb_gnt[1] ? DATA1 : DATA0;
        end else if ((state == ST_START) || (state == ST_DATA)) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state   <= ST_IDLE;
            GNT     <= GNT_NONE;
            T_OUT   <= 1'b1;
            I_OUT   <= 1'b0;
            ACK0    <= 1'b0;
            ACK1    <= 1'b0;
            BUSY    <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_take) begin
                        state <= ST_START;
                        GNT   <= arb_gnt;
                        T_OUT <= 1'b0;
                        I_OUT <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end
                ST_START: begin
                    state   <= ST_DATA;
                    I_OUT   <= shreg[0];
                    bit_cnt <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        state <= ST_STOP;
                        I_OUT <= 1'b0;
                        ACK0  <= GNT[0];
                        ACK1  <= GNT[1];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        I_OUT   <= shreg[0];
                    end
                end
                ST_STOP: begin
                    state   <= ST_GAP;
                    T_OUT   <= 1'b1;
                    ACK0    <= 1'b0;
                    ACK1    <= 1'b0;
                    gap_cnt <= '0;
                end
                ST_GAP: begin
                    // GNT stays with the owner through turnaround.
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        GNT   <= GNT_NONE;
                        BUSY  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lvds_tx_arbiter
// Three instances (TURN = 2, 1, 15) share one stimulus. A frame-level model
// queues the expected output of every cycle of a granted word; outputs are
// compared with it on each falling edge, alongside directed literal checks.
// ---------------------------------------------------------------------------
module tb_lvds_tx_arbiter;
    import lvds_tx_pkg::*;

    localparam int DW = 8;
    localparam int NI = 3;

    typedef struct packed {
        logic       t;
        logic       i;
        logic [1:0] gnt;
        logic       a0;
        logic       a1;
        logic       busy;
    } obs_t;

    function automatic int turn_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    function automatic obs_t mk(input logic t, input logic i, input logic [1:0] gnt,
                                input logic a0, input logic a1, input logic busy);
        obs_t o;
        o.t = t; o.i = i; o.gnt = gnt; o.a0 = a0; o.a1 = a1; o.busy = busy;
        return o;
    endfunction

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [DW-1:0] data0 = '0;
    logic [DW-1:0] data1 = '0;

    logic [NI-1:0] a0_w, a1_w, i_w, t_w, busy_w;
    logic [1:0]    gnt_w [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        lvds_tx_arbiter #(
            .TURN ((g == 0) ? 2 : ((g == 1) ? 1 : 15)),
            .DW   (DW)
        ) dut (
            .C     (clk),
            .CLR   (clr),
            .REQ0  (req0),
            .DATA0 (data0),
            .ACK0  (a0_w[g]),
            .REQ1  (req1),
            .DATA1 (data1),
            .ACK1  (a1_w[g]),
            .GNT   (gnt_w[g]),
            .I_OUT (i_w[g]),
            .T_OUT (t_w[g]),
            .BUSY  (busy_w[g])
        );
    end

    // Reference model: when idle and someone requests, the whole frame of
    // expected outputs (start, data LSB first, stop+ack, TURN gap cycles,
    // one idle cycle) is queued and then replayed one entry per clock.
    obs_t mq   [NI][$];
    obs_t mexp [NI];
    logic mlast1 [NI];

    always @(posedge clk or posedge clr) begin
        int            w;
        logic [1:0]    gg;
        logic [DW-1:0] word;
        for (int g = 0; g < NI; g++) begin
            if (clr) begin
                mq[g].delete();
                mexp[g]   = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
                mlast1[g] = 1'b1;
            end else if (mq[g].size() != 0) begin
                mexp[g] = mq[g].pop_front();
            end else if (req0 || req1) begin
                w         = (req0 && req1) ? (mlast1[g] ? 0 : 1) : (req1 ? 1 : 0);
                mlast1[g] = (w == 1);
                word      = (w == 1) ? data1 : data0;
                gg        = (w == 1) ? 2'b10 : 2'b01;
                mq[g].push_back(mk(1'b0, 1'b1, gg, 1'b0, 1'b0, 1'b1));
                for (int b = 0; b < DW; b++)
                    mq[g].push_back(mk(1'b0, word[b], gg, 1'b0, 1'b0, 1'b1));
                mq[g].push_back(mk(1'b0, 1'b0, gg, w == 0, w == 1, 1'b1));
                for (int k = 0; k < turn_of(g); k++)
                    mq[g].push_back(mk(1'b1, 1'b0, gg, 1'b0, 1'b0, 1'b1));
                mq[g].push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
                mexp[g] = mq[g].pop_front();
            end else begin
                mexp[g] = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t obs_now(input int g);
        return mk(t_w[g], i_w[g], gnt_w[g], a0_w[g], a1_w[g], busy_w[g]);
    endfunction

    // Advance to the next falling edge and compare every instance with the model.
    task automatic step();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("model[%0d]", g), 32'(obs_now(g)), 32'(mexp[g]));
            check($sformatf("ack_excl[%0d]", g), 32'(a0_w[g] & a1_w[g]), 32'd0);
        end
    endtask

    logic [0:9]    iv, tv, av;
    logic [DW-1:0] byte_r;
    logic [1:0]    gseq [4];
    int            gcyc [4];
    int            gcount [NI];
    int            ng, nack, nrise;
    logic [1:0]    pg;

    initial begin
        // Reset state
        step();
        step();
        check("reset_t_out", 32'(t_w), 32'b111);
        check("reset_busy", 32'(busy_w), 32'b000);
        check("reset_gnt", 32'(gnt_w[0]), 32'b00);
        clr = 1'b0;

        // Single word 0xA5
        step();
        req0 = 1'b1; data0 = 8'hA5;
        step();
        req0 = 1'b0; data0 = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) step();
            iv[k] = i_w[0]; tv[k] = t_w[0]; av[k] = a0_w[0];
        end
        check("a5_i_out", 32'(iv), 32'(10'b1101001010));
        check("a5_t_out", 32'(tv), 32'd0);
        check("a5_ack0", 32'(av), 32'(10'b0000000001));
        for (int g = 0; g < NI; g++) gcount[g] = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            for (int g = 0; g < NI; g++)
                if (busy_w[g] && t_w[g]) gcount[g]++;
        end
        for (int g = 0; g < NI; g++)
            check($sformatf("gap_len[%0d]", g), 32'(gcount[g]), 32'(turn_of(g)));
        check("a5_back_idle", 32'(busy_w), 32'd0);

        // Contention from reset
        clr = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'h01; data1 = 8'h80;
        step();
        clr = 1'b0;
        ng = 0; pg = 2'b00;
        for (int k = 0; k < 60; k++) begin
            step();
            if ((pg == 2'b00) && (gnt_w[0] != 2'b00) && (ng < 4)) begin
                gseq[ng] = gnt_w[0]; gcyc[ng] = k; ng++;
            end
            pg = gnt_w[0];
        end
        check("cont_grants", 32'(ng), 32'd4);
        check("cont_gnt_seq", 32'({gseq[0], gseq[1], gseq[2], gseq[3]}), 32'(8'b01_10_01_10));
        check("cont_space1", 32'(gcyc[1] - gcyc[0]), 32'd13);
        check("cont_space2", 32'(gcyc[2] - gcyc[1]), 32'd13);
        check("cont_space3", 32'(gcyc[3] - gcyc[2]), 32'd13);
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 30; k++) step();

        // Data changed after grant
        req1 = 1'b1; data1 = 8'h3C;
        step();
        data1 = 8'hFF;
        for (int b = 0; b < DW; b++) begin
            step();
            byte_r[b] = i_w[0];
        end
        step();
        check("stable_ack1", 32'(a1_w[0]), 32'd1);
        req1 = 1'b0;
        check("stable_word", 32'(byte_r), 32'h3C);
        for (int k = 0; k < 30; k++) step();

        // Reset during data bit 4
        req1 = 1'b1; data1 = 8'h5A;
        step();
        for (int k = 0; k < 5; k++) step();
        #2 clr = 1'b1;
        #1;
        check("midclr_t_out", 32'(t_w), 32'b111);
        check("midclr_busy", 32'(busy_w), 32'b000);
        check("midclr_ack", 32'(a1_w | a0_w), 32'b000);
        step();
        clr = 1'b0;
        nack = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (a1_w[0]) begin nack++; req1 = 1'b0; end
        end
        check("midclr_next_ack", 32'(nack), 32'd1);
        for (int k = 0; k < 20; k++) step();

        // Early request drop during START
        req1 = 1'b1; data1 = 8'hC3;
        step();
        req1 = 1'b0;
        nack = 0; nrise = 0; pg = gnt_w[0];
        for (int k = 0; k < 30; k++) begin
            step();
            if (a1_w[0]) nack++;
            if ((pg == 2'b00) && (gnt_w[0] != 2'b00)) nrise++;
            pg = gnt_w[0];
        end
        check("drop_ack_once", 32'(nack), 32'd1);
        check("drop_no_regrant", 32'(nrise), 32'd0);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #2 clr = 1'b1;
                step();
                clr = 1'b0;
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
